// File: rtl/obj_sched_if.sv
// Object-table write channel and glyph-memory read port between obj_sched and its host.
interface obj_sched_if #(
    parameter int GAW = 8
);
    logic           wr_valid;
    logic           wr_ready;
    logic [2:0]     wr_idx;
    logic           wr_en_obj;
    logic [9:0]     wr_x_start;
    logic [9:0]     wr_x_end;
    logic [9:0]     wr_y_start;
    logic [9:0]     wr_y_end;
    logic [1:0]     wr_mode;
    logic [23:0]    wr_color;
    logic [GAW-1:0] wr_gaddr;
    logic           gmem_rd;
    logic [GAW-1:0] gmem_addr;
    logic [63:0]    gmem_data;

    modport master (
        output wr_valid, wr_idx, wr_en_obj, wr_x_start, wr_x_end, wr_y_start, wr_y_end,
        output wr_mode, wr_color, wr_gaddr, gmem_data,
        input  wr_ready, gmem_rd, gmem_addr
    );

    modport slave (
        input  wr_valid, wr_idx, wr_en_obj, wr_x_start, wr_x_end, wr_y_start, wr_y_end,
        input  wr_mode, wr_color, wr_gaddr, gmem_data,
        output wr_ready, gmem_rd, gmem_addr
    );
endinterface

// File: rtl/obj_sched.sv
// Object table with per-pixel lowest-index hit selection and a vblank glyph fetch engine.
// Optional build macro SHADOW_TABLE_EN: writes land in a shadow table copied to the live table at the fetch trigger.
module obj_sched #(
    parameter int NUM_OBJ  = 8,
    parameter int GAW      = 8,
    parameter int V_ACTIVE = 480
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [9:0]  hcount,
    input  logic [9:0]  vcount,
    input  logic        bright,
    obj_sched_if.slave  bus,
    output logic        obj_hit,
    output logic [1:0]  obj_mode,
    output logic [9:0]  obj_x_start,
    output logic [9:0]  obj_x_end,
    output logic [9:0]  obj_y_start,
    output logic [9:0]  obj_y_end,
    output logic [23:0] obj_color,
    output logic [63:0] obj_glyph,
    output logic        fetch_done
);

    localparam int         IW         = (NUM_OBJ > 1) ? $clog2(NUM_OBJ) : 1;
    localparam logic [1:0] MODE_GLYPH = 2'b01;

    typedef struct packed {
        logic           en;
        logic [9:0]     x_start;
        logic [9:0]     x_end;
        logic [9:0]     y_start;
        logic [9:0]     y_end;
        logic [1:0]     mode;
        logic [23:0]    color;
        logic [GAW-1:0] gaddr;
    } entry_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        CAP  = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [IW-1:0]  idx_q, idx_d;

    entry_t         live_q  [NUM_OBJ];
    logic [63:0]    glyph_q [NUM_OBJ];
`ifdef SHADOW_TABLE_EN
    entry_t         shadow_q [NUM_OBJ];
`endif

    entry_t         wr_entry;
    logic           wr_fire;
    logic           trigger;
    logic           last;
    logic           cur_fetch;

    logic           ready_c;
    logic           rd_c;
    logic [GAW-1:0] addr_c;
    logic           done_c;
    logic           cap_c;

    logic [NUM_OBJ-1:0] hit_vec;
    logic           obj_hit_q,     obj_hit_d;
    logic [1:0]     obj_mode_q,    obj_mode_d;
    logic [9:0]     obj_x_start_q, obj_x_start_d;
    logic [9:0]     obj_x_end_q,   obj_x_end_d;
    logic [9:0]     obj_y_start_q, obj_y_start_d;
    logic [9:0]     obj_y_end_q,   obj_y_end_d;
    logic [23:0]    obj_color_q,   obj_color_d;
    logic [63:0]    obj_glyph_q,   obj_glyph_d;

    assign wr_entry = '{
        en:      bus.wr_en_obj,
        x_start: bus.wr_x_start,
        x_end:   bus.wr_x_end,
        y_start: bus.wr_y_start,
        y_end:   bus.wr_y_end,
        mode:    bus.wr_mode,
        color:   bus.wr_color,
        gaddr:   bus.wr_gaddr
    };

    assign wr_fire   = bus.wr_valid && ready_c;
    assign trigger   = (state_q == IDLE) && (hcount == 10'd0) && (vcount == 10'(V_ACTIVE));
    assign last      = (idx_q == IW'(NUM_OBJ - 1));
    assign cur_fetch = live_q[idx_q].en && (live_q[idx_q].mode == MODE_GLYPH);

    // ---- fetch FSM: state register ----
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // ---- fetch FSM: next state ----
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        unique case (state_q)
            IDLE: begin
                if (trigger) begin
                    state_d = RD;
                    idx_d   = '0;
                end
            end
            RD: begin
                if (cur_fetch) begin
                    state_d = CAP;
                end else if (last) begin
                    state_d = IDLE;
                end else begin
                    idx_d = idx_q + IW'(1);
                end
            end
            CAP: begin
                if (last) begin
                    state_d = IDLE;
                end else begin
                    state_d = RD;
                    idx_d   = idx_q + IW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // ---- fetch FSM: outputs (reset squashes any in-flight read or capture) ----
    always_comb begin
`ifdef SHADOW_TABLE_EN
        ready_c = 1'b1;
`else
        ready_c = (state_q == IDLE);
`endif
        rd_c   = 1'b0;
        addr_c = '0;
        done_c = 1'b0;
        cap_c  = 1'b0;
        unique case (state_q)
            RD: begin
                if (cur_fetch) begin
                    rd_c   = 1'b1;
                    addr_c = live_q[idx_q].gaddr;
                end else if (last) begin
                    done_c = 1'b1;
                end
            end
            CAP: begin
                cap_c  = 1'b1;
                done_c = last;
            end
            default: ;
        endcase
        if (reset) begin
            rd_c   = 1'b0;
            addr_c = '0;
            done_c = 1'b0;
            cap_c  = 1'b0;
        end
    end

    assign bus.wr_ready  = ready_c;
    assign bus.gmem_rd   = rd_c;
    assign bus.gmem_addr = addr_c;
    assign fetch_done    = done_c;

    // ---- object table and glyph store ----
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_OBJ; i++) begin
                live_q[i]   <= '0;
                glyph_q[i]  <= '0;
`ifdef SHADOW_TABLE_EN
                shadow_q[i] <= '0;
`endif
            end
        end else begin
            for (int i = 0; i < NUM_OBJ; i++) begin
`ifdef SHADOW_TABLE_EN
                // The trigger-cycle write is merged into the copy so that fetch sees it.
                if (wr_fire && (int'(bus.wr_idx) == i)) begin
                    shadow_q[i] <= wr_entry;
                end
                if (trigger) begin
                    live_q[i] <= (wr_fire && (int'(bus.wr_idx) == i)) ? wr_entry : shadow_q[i];
                end
`else
                if (wr_fire && (int'(bus.wr_idx) == i)) begin
                    live_q[i] <= wr_entry;
                end
`endif
                if (cap_c && (int'(idx_q) == i)) begin
                    glyph_q[i] <= bus.gmem_data;
                end
            end
        end
    end

    // ---- pixel hit test and priority select ----
    always_comb begin
        hit_vec = '0;
        for (int i = 0; i < NUM_OBJ; i++) begin
            hit_vec[i] = live_q[i].en && bright &&
                         (live_q[i].y_start <= vcount) && (vcount < live_q[i].y_end) &&
                         (live_q[i].x_start <= hcount) && (hcount < live_q[i].x_end);
        end
    end

    always_comb begin
        obj_hit_d     = 1'b0;
        obj_mode_d    = '0;
        obj_x_start_d = '0;
        obj_x_end_d   = '0;
        obj_y_start_d = '0;
        obj_y_end_d   = '0;
        obj_color_d   = '0;
        obj_glyph_d   = '0;
        // Walking downward lets the lowest hitting index overwrite the rest.
        for (int i = NUM_OBJ - 1; i >= 0; i--) begin
            if (hit_vec[i]) begin
                obj_hit_d     = 1'b1;
                obj_mode_d    = live_q[i].mode;
                obj_x_start_d = live_q[i].x_start;
                obj_x_end_d   = live_q[i].x_end;
                obj_y_start_d = live_q[i].y_start;
                obj_y_end_d   = live_q[i].y_end;
                obj_color_d   = live_q[i].color;
                obj_glyph_d   = glyph_q[i];
            end
        end
    end

    // ---- registered pixel outputs ----
    always_ff @(posedge clk) begin
        if (reset) begin
            obj_hit_q     <= 1'b0;
            obj_mode_q    <= '0;
            obj_x_start_q <= '0;
            obj_x_end_q   <= '0;
            obj_y_start_q <= '0;
            obj_y_end_q   <= '0;
            obj_color_q   <= '0;
            obj_glyph_q   <= '0;
        end else begin
            obj_hit_q     <= obj_hit_d;
            obj_mode_q    <= obj_mode_d;
            obj_x_start_q <= obj_x_start_d;
            obj_x_end_q   <= obj_x_end_d;
            obj_y_start_q <= obj_y_start_d;
            obj_y_end_q   <= obj_y_end_d;
            obj_color_q   <= obj_color_d;
            obj_glyph_q   <= obj_glyph_d;
        end
    end

    assign obj_hit     = obj_hit_q;
    assign obj_mode    = obj_mode_q;
    assign obj_x_start = obj_x_start_q;
    assign obj_x_end   = obj_x_end_q;
    assign obj_y_start = obj_y_start_q;
    assign obj_y_end   = obj_y_end_q;
    assign obj_color   = obj_color_q;
    assign obj_glyph   = obj_glyph_q;

endmodule
